// File: rtl/magnitude_compare_pkg.sv
// Shared types and defaults for the magnitude compare arbiter.
// Holds the FSM state encoding and the default operand width.
package magnitude_compare_pkg;

  localparam int WIDTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESPOND = 2'd2
  } state_e;

endpackage

// File: rtl/magnitude_compare_arbiter_if.sv
// Request/response bundle between two requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface magnitude_compare_arbiter_if
  import magnitude_compare_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             req0_valid;
  logic             req1_valid;
  logic             req0_ready;
  logic             req1_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic             rsp0_ready;
  logic             rsp1_ready;
  logic             rsp_a_less_b;
  logic             rsp_a_greater_b;
  logic             rsp_a_equal_b;

  modport master (
    output req0_valid, req1_valid,
    output req0_a, req0_b,
    output req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid,
    input  rsp_a_less_b,
    input  rsp_a_greater_b,
    input  rsp_a_equal_b
  );

  modport slave (
    input  req0_valid, req1_valid,
    input  req0_a, req0_b,
    input  req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid,
    output rsp_a_less_b,
    output rsp_a_greater_b,
    output rsp_a_equal_b
  );

endinterface

// File: rtl/magnitude_comparator_nbit.sv
// Combinational unsigned magnitude comparator.
// Exactly one of the three outputs is high for any input pair.
module magnitude_comparator_nbit
  import magnitude_compare_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_less_b,
  output logic             a_greater_b,
  output logic             a_equal_b
);

  assign a_less_b    = (a < b);
  assign a_greater_b = (a > b);
  assign a_equal_b   = (a == b);

endmodule

// File: rtl/magnitude_compare_arbiter.sv
// Two-requester round-robin arbiter sharing one comparator.
// Define CMP_ARB_STATS_EN to add saturating per-requester grant counters.
module magnitude_compare_arbiter
  import magnitude_compare_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  magnitude_compare_arbiter_if.slave  bus
`ifdef CMP_ARB_STATS_EN
  ,
  output logic [7:0]                  grant_cnt0,
  output logic [7:0]                  grant_cnt1
`endif
);

  state_e           state;
  logic             prio;
  logic             gnt_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             lt_q;
  logic             gt_q;
  logic             eq_q;
  logic             lt_c;
  logic             gt_c;
  logic             eq_c;
  logic             in_idle;
  logic             in_rsp;
  logic             gnt0;
  logic             gnt1;
  logic             accept;
  logic             done;

  magnitude_comparator_nbit #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a           (op_a),
    .b           (op_b),
    .a_less_b    (lt_c),
    .a_greater_b (gt_c),
    .a_equal_b   (eq_c)
  );

  // prio=1 means req1 wins a tie; it points past the last served.
  assign in_idle = (state == IDLE) && !rst;
  assign in_rsp  = (state == RESPOND);
  assign gnt1    = in_idle && bus.req1_valid
                && (!bus.req0_valid || prio);
  assign gnt0    = in_idle && bus.req0_valid && !gnt1;
  assign accept  = gnt0 || gnt1;

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp0_valid = in_rsp && !gnt_id;
  assign bus.rsp1_valid = in_rsp && gnt_id;

  assign bus.rsp_a_less_b    = in_rsp && lt_q;
  assign bus.rsp_a_greater_b = in_rsp && gt_q;
  assign bus.rsp_a_equal_b   = in_rsp && eq_q;

  assign done = (bus.rsp0_valid && bus.rsp0_ready)
             || (bus.rsp1_valid && bus.rsp1_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      prio   <= 1'b0;
      gnt_id <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      lt_q   <= 1'b0;
      gt_q   <= 1'b0;
      eq_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            gnt_id <= gnt1;
            op_a   <= gnt1 ? bus.req1_a : bus.req0_a;
            op_b   <= gnt1 ? bus.req1_b : bus.req0_b;
            state  <= COMPARE;
          end
        end
        COMPARE: begin
          lt_q  <= lt_c;
          gt_q  <= gt_c;
          eq_q  <= eq_c;
          state <= RESPOND;
        end
        RESPOND: begin
          if (done) begin
            prio  <= ~gnt_id;
            lt_q  <= 1'b0;
            gt_q  <= 1'b0;
            eq_q  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CMP_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= 8'd0;
      grant_cnt1 <= 8'd0;
    end else begin
      if (gnt0 && grant_cnt0 != 8'hFF)
        grant_cnt0 <= grant_cnt0 + 8'd1;
      if (gnt1 && grant_cnt1 != 8'hFF)
        grant_cnt1 <= grant_cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_magnitude_compare_arbiter.sv
// Directed self-checking bench for magnitude_compare_arbiter.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_magnitude_compare_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  magnitude_compare_arbiter_if #(.WIDTH(2)) bus ();

`ifdef CMP_ARB_STATS_EN
  logic [7:0] grant_cnt0;
  logic [7:0] grant_cnt1;
`endif

  magnitude_compare_arbiter #(.WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef CMP_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  logic [2:0] flags;
  logic [6:0] all_out;
  assign flags = {bus.rsp_a_less_b,
                  bus.rsp_a_greater_b,
                  bus.rsp_a_equal_b};
  assign all_out = {bus.req0_ready, bus.req1_ready,
                    bus.rsp0_valid, bus.rsp1_valid,
                    flags};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a     = 2'd0;
    bus.req0_b     = 2'd0;
    bus.req1_a     = 2'd0;
    bus.req1_b     = 2'd0;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (all_out !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=%b",
               all_out, 7'b0);
    end
`ifdef CMP_ARB_STATS_EN
    checks++;
    if (grant_cnt0 !== 8'd0 || grant_cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d/%0d want=0/0",
               grant_cnt0, grant_cnt1);
    end
`endif
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single_req0();
    bus.req0_a = 2'b01;
    bus.req0_b = 2'b10;
    bus.req0_valid = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready got=%b want=10",
               {bus.req0_ready, bus.req1_ready});
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    checks++;
    if (all_out !== 7'b0) begin
      errors++;
      $display("FAIL single_cycle1 got=%b want=0", all_out);
    end
    @(negedge clk);
    checks++;
    if (all_out !== 7'b0010_100) begin
      errors++;
      $display("FAIL single_rsp got=%b want=%b",
               all_out, 7'b0010_100);
    end
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (all_out !== 7'b0) begin
      errors++;
      $display("FAIL single_done got=%b want=0", all_out);
    end
    bus.rsp0_ready = 1'b0;
  endtask

  task automatic test_both_round_robin();
    bus.req0_a = 2'b11;
    bus.req0_b = 2'b11;
    bus.req1_a = 2'b10;
    bus.req1_b = 2'b01;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rr_first_grant got=%b want=10",
               {bus.req0_ready, bus.req1_ready});
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== 7'b0010_001) begin
      errors++;
      $display("FAIL rr_rsp0 got=%b want=%b",
               all_out, 7'b0010_001);
    end
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rr_second_grant got=%b want=01",
               {bus.req0_ready, bus.req1_ready});
    end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== 7'b0001_010) begin
      errors++;
      $display("FAIL rr_rsp1 got=%b want=%b",
               all_out, 7'b0001_010);
    end
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.rsp1_ready = 1'b0;
    #1;
    checks++;
    if (all_out !== 7'b0) begin
      errors++;
      $display("FAIL rr_done got=%b want=0", all_out);
    end
  endtask

  task automatic test_stall();
    bus.req0_a = 2'b11;
    bus.req0_b = 2'b00;
    bus.req0_valid = 1'b1;
    @(negedge clk);
    bus.req1_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (all_out !== 7'b0010_010) begin
        errors++;
        $display("FAIL stall_hold[%0d] got=%b want=%b",
                 i, all_out, 7'b0010_010);
      end
      @(negedge clk);
    end
    checks++;
    if (all_out !== 7'b0010_010) begin
      errors++;
      $display("FAIL stall_last got=%b want=%b",
               all_out, 7'b0010_010);
    end
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    #1;
    checks++;
    if (all_out !== 7'b0100_000) begin
      errors++;
      $display("FAIL stall_done got=%b want=%b",
               all_out, 7'b0100_000);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_reset_in_compare();
    bus.req0_a = 2'b10;
    bus.req0_b = 2'b01;
    bus.req0_valid = 1'b1;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.rsp0_ready = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (all_out !== 7'b0) begin
      errors++;
      $display("FAIL rstc_now got=%b want=0", all_out);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.rsp0_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (all_out !== 7'b0) begin
        errors++;
        $display("FAIL rstc_quiet[%0d] got=%b want=0",
                 i, all_out);
      end
    end
    bus.req1_a = 2'b00;
    bus.req1_b = 2'b11;
    bus.req1_valid = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rstc_grant got=%b want=01",
               {bus.req0_ready, bus.req1_ready});
    end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== 7'b0001_100) begin
      errors++;
      $display("FAIL rstc_rsp got=%b want=%b",
               all_out, 7'b0001_100);
    end
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_all_pairs();
    logic [2:0] want;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        want = {a < b, a > b, a == b};
        bus.req1_a = a[1:0];
        bus.req1_b = b[1:0];
        bus.req1_valid = 1'b1;
        #1;
        checks++;
        if (bus.req1_ready !== 1'b1) begin
          errors++;
          $display("FAIL pair_ready a=%0d b=%0d got=%b want=1",
                   a, b, bus.req1_ready);
        end
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (all_out !== {4'b0001, want}) begin
          errors++;
          $display("FAIL pair a=%0d b=%0d got=%b want=%b",
                   a, b, all_out, {4'b0001, want});
        end
        bus.rsp1_ready = 1'b1;
        @(negedge clk);
        bus.rsp1_ready = 1'b0;
      end
    end
  endtask

`ifdef CMP_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    bus.req0_a = 2'b01;
    bus.req0_b = 2'b01;
    bus.req0_valid = 1'b1;
    bus.rsp0_ready = 1'b1;
    repeat (900) @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.rsp0_ready = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (grant_cnt0 !== 8'd255 || grant_cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL stats_sat got=%0d/%0d want=255/0",
               grant_cnt0, grant_cnt1);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_single_req0();
    do_reset();
    test_both_round_robin();
    test_stall();
    test_reset_in_compare();
    test_all_pairs();
`ifdef CMP_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/magnitude_compare_arbiter.md
MAGNITUDE_COMPARE_ARBITER -- requirements
Module: magnitude_compare_arbiter

Interface
REQ-001 Parameter WIDTH, default 2, SHALL set the operand width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 req0_valid, req1_valid  input  1 each  SHALL mean the requester presents a compare request.
REQ-005 req0_ready, req1_ready  output  1 each  SHALL mean the request is accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  SHALL be the operands A and B.
REQ-007 rsp0_valid, rsp1_valid  output  1 each  SHALL mean a result is presented to that requester.
REQ-008 rsp0_ready, rsp1_ready  input  1 each  SHALL mean the requester consumes the result this cycle.
REQ-009 rsp_a_less_b, rsp_a_greater_b, rsp_a_equal_b  output  1 each  SHALL be the shared result flags.

Function
REQ-010 The block SHALL share one comparator between two requesters through FSM states IDLE, COMPARE and RESPOND.
REQ-011 IDLE: if any reqN_valid, SHALL grant one requester, assert its reqN_ready combinationally that cycle, latch its A/B and grant id, and go to COMPARE.
REQ-012 Only one reqN_ready SHALL be high in any cycle; both SHALL be low outside IDLE.
REQ-013 Both valid in IDLE: SHALL grant the requester not served last (round-robin); after reset req0 SHALL have priority.
REQ-014 COMPARE: SHALL register the comparator result (unsigned compare of latched A, B) and go to RESPOND.
REQ-015 RESPOND: SHALL assert rspN_valid for the granted requester only, with exactly one flag high.
REQ-016 RESPOND: rspN_valid, the flags and the latched operands SHALL stay stable until rspN_ready is high; that cycle SHALL complete the transaction, toggle the round-robin pointer and return to IDLE.
REQ-017 Latency SHALL be 2 cycles from accept (ready&valid) to rspN_valid; peak throughput SHALL be one transaction per 3 cycles.
REQ-018 Result flags SHALL be 0 whenever no rspN_valid is high.
REQ-019 reqN_ready SHALL depend on reqN_valid; requesters SHALL NOT make valid depend on ready.
REQ-020 rspN_ready asserted while rspN_valid is low SHALL have no effect.

Reset
REQ-021 rst high SHALL immediately force state IDLE, all ready/valid/flag outputs 0, round-robin pointer to req0, and clear latched operands.
REQ-022 rst asserted in COMPARE or RESPOND SHALL discard the in-flight transaction with no response issued.

Configuration
REQ-023 Macro CMP_ARB_STATS_EN defined: SHALL add outputs grant_cnt0, grant_cnt1 (8 bits each), incremented per accept, saturating at 255, cleared by rst.
REQ-024 CMP_ARB_STATS_EN undefined: those ports and counters SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-025 Package magnitude_compare_pkg SHALL hold the FSM state enum (IDLE, COMPARE, RESPOND) and the default WIDTH constant.
REQ-026 The comparator SHALL be a sub-module magnitude_comparator_nbit (WIDTH-parameterised, combinational, outputs a_less_b/a_greater_b/a_equal_b) instantiated once.

Verification
REQ-027 Reset, then req0 A=01 B=10 -> req0_ready in cycle 0, rsp0_valid in cycle 2 with a_less_b=1 and the other flags 0.
REQ-028 Both valid in the same cycle after reset, req0 A=11 B=11, req1 A=10 B=01 -> req0 served first (a_equal_b=1), then req1 (a_greater_b=1).
REQ-029 rsp0_ready held low 5 cycles in RESPOND -> rsp0_valid and flags stable, both req ready low, then completion on the cycle rsp0_ready rises.
REQ-030 rst pulsed while in COMPARE -> all outputs 0 next cycle, no rsp issued; a subsequent lone req1 request is granted normally.
REQ-031 All 16 A/B pairs on req1, with req0 idle -> exactly one flag high, matching an integer compare, every time.
REQ-032 With CMP_ARB_STATS_EN, 300 back-to-back req0 transactions -> grant_cnt0=255, grant_cnt1=0.
